// File: rtl/harz_multi_host_arbiter.sv
// Round-robin arbiter of NUM_CH host request channels plus the Z80 CPU onto one registered MSX slot bus.
// Optional slot-busy timeout is built when HARZ_ARB_TIMEOUT_EN is defined.
module harz_multi_host_arbiter #(
    parameter int NUM_CH      = 2,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 8,
    parameter int SETTLE_CYC  = 1,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic                     i_CLK,
    input  logic                     i_RST_n,
    input  logic [3*NUM_CH-1:0]      i_req,
    input  logic [ADDR_W*NUM_CH-1:0] i_addr,
    input  logic [DATA_W*NUM_CH-1:0] i_wdata,
    output logic [DATA_W-1:0]        o_rdata,
    output logic [NUM_CH-1:0]        o_busy,
    output logic [NUM_CH-1:0]        o_done,
    output logic [NUM_CH-1:0]        o_err,
    input  logic                     i_cpu_mreq_n,
    input  logic                     i_cpu_iorq_n,
    input  logic                     i_cpu_rd_n,
    input  logic                     i_cpu_wr_n,
    input  logic [ADDR_W-1:0]        i_cpu_a,
    input  logic [DATA_W-1:0]        i_cpu_dout,
    output logic [DATA_W-1:0]        o_cpu_di,
    output logic                     o_cpu_wait_n,
    output logic                     o_slot_iorq,
    output logic                     o_slot_merq,
    output logic                     o_slot_wr,
    output logic                     o_slot_rd,
    output logic [ADDR_W-1:0]        o_slot_a,
    output logic [DATA_W-1:0]        o_slot_wdata,
    input  logic                     i_slot_busy,
    input  logic [DATA_W-1:0]        i_slot_rdata,
    output logic [1:0]               o_dbg_state
);
    localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {IDLE, SETTLE, WAITBUSY, FINISH} state_t;
    state_t state, state_nxt;

    logic [PW-1:0]     ptr, grant_ch;
    logic [2:0]        grant_code;
    logic              grant_vld, owner_host, cpu_idle, wb_exit, tmo_hit;
    logic [2:0]        ch_code [NUM_CH];
    logic [NUM_CH-1:0] ch_valid;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              lat_rd, lat_wr, lat_iorq, lat_merq;
    logic [3:0]        settle_cnt;

    assign cpu_idle = i_cpu_mreq_n & i_cpu_iorq_n;

    // Search starts just after the last granted channel: first pass above ptr, second pass wraps.
    always_comb begin
        grant_vld  = 1'b0;
        grant_ch   = ptr;
        grant_code = 3'd0;
        for (int c = 0; c < NUM_CH; c++) begin
            ch_code[c]  = i_req[c*3 +: 3];
            ch_valid[c] = (ch_code[c] >= 3'd1) && (ch_code[c] <= 3'd4);
        end
        for (int c = 0; c < NUM_CH; c++) begin
            if (!grant_vld && (c > int'(ptr)) && ch_valid[c]) begin
                grant_vld = 1'b1; grant_ch = PW'(c); grant_code = ch_code[c];
            end
        end
        for (int c = 0; c < NUM_CH; c++) begin
            if (!grant_vld && (c <= int'(ptr)) && ch_valid[c]) begin
                grant_vld = 1'b1; grant_ch = PW'(c); grant_code = ch_code[c];
            end
        end
        grant_vld = grant_vld & cpu_idle;
    end

`ifdef HARZ_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmo_cnt;

    always_ff @(posedge i_CLK) begin
        if (!i_RST_n || state != WAITBUSY) tmo_cnt <= '0;
        else                                tmo_cnt <= tmo_cnt + TW'(1);
    end
    assign tmo_hit = i_slot_busy && (tmo_cnt == TW'(TIMEOUT_CYC - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge i_CLK) begin
        if (!i_RST_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (grant_vld) state_nxt = SETTLE;
            SETTLE:   if (settle_cnt <= 4'd1) state_nxt = WAITBUSY;
            WAITBUSY: if (wb_exit) state_nxt = FINISH;
            FINISH:   state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        wb_exit      = (state == WAITBUSY) && (!i_slot_busy || tmo_hit);
        o_cpu_wait_n = ~(i_slot_busy | (owner_host & ~cpu_idle));
        o_cpu_di     = i_slot_rdata;
        o_dbg_state  = state;
    end

    always_ff @(posedge i_CLK) begin
        if (!i_RST_n) begin
            {o_slot_iorq, o_slot_merq, o_slot_wr, o_slot_rd} <= 4'b0;
            o_slot_a     <= '0;
            o_slot_wdata <= '0;
            o_rdata      <= '0;
            o_busy       <= '0;
            o_done       <= '0;
            o_err        <= '0;
            ptr          <= PW'(NUM_CH - 1);
            owner_host   <= 1'b0;
            lat_addr     <= '0;
            lat_wdata    <= '0;
            {lat_iorq, lat_merq, lat_wr, lat_rd} <= 4'b0;
            settle_cnt   <= '0;
        end else begin
            if (owner_host) begin
                {o_slot_iorq, o_slot_merq, o_slot_wr, o_slot_rd} <= {lat_iorq, lat_merq, lat_wr, lat_rd};
                o_slot_a     <= lat_addr;
                o_slot_wdata <= lat_wdata;
            end else begin
                {o_slot_iorq, o_slot_merq, o_slot_wr, o_slot_rd} <=
                    ~{i_cpu_iorq_n, i_cpu_mreq_n, i_cpu_wr_n, i_cpu_rd_n};
                o_slot_a     <= i_cpu_a;
                o_slot_wdata <= i_cpu_dout;
            end
            o_done <= '0;
            o_err  <= '0;
            case (state)
                IDLE: if (grant_vld) begin
                    lat_addr   <= i_addr[int'(grant_ch)*ADDR_W +: ADDR_W];
                    lat_wdata  <= i_wdata[int'(grant_ch)*DATA_W +: DATA_W];
                    lat_merq   <= (grant_code == 3'd1) || (grant_code == 3'd2);
                    lat_iorq   <= (grant_code == 3'd3) || (grant_code == 3'd4);
                    lat_rd     <= (grant_code == 3'd1) || (grant_code == 3'd3);
                    lat_wr     <= (grant_code == 3'd2) || (grant_code == 3'd4);
                    owner_host <= 1'b1;
                    o_busy[grant_ch] <= 1'b1;
                    ptr        <= grant_ch;
                    settle_cnt <= 4'(SETTLE_CYC);
                end
                SETTLE: if (settle_cnt > 4'd1) settle_cnt <= settle_cnt - 4'd1;
                // rd/wr drop here; iorq/merq follow one cycle later in FINISH.
                WAITBUSY: if (wb_exit) begin
                    lat_rd <= 1'b0;
                    lat_wr <= 1'b0;
                    if (lat_rd) o_rdata <= tmo_hit ? '1 : i_slot_rdata;
                    o_busy[ptr] <= 1'b0;
                    o_done[ptr] <= 1'b1;
                    o_err[ptr]  <= tmo_hit;
                end
                FINISH: begin
                    lat_iorq   <= 1'b0;
                    lat_merq   <= 1'b0;
                    owner_host <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule
